// File: rtl/deck_shuffler_pkg.sv
// deck_shuffler_pkg
// Shared deck geometry, the shuffle state encoding and the 16-bit LFSR step
// used by the deck shuffler and by any other randomised block.
package deck_shuffler_pkg;

  localparam int DECK_SIZE   = 52;
  localparam int CARD_W      = 7;
  localparam int DECK_ADDR_W = 6;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PICK = 3'd1,
    RD_I = 3'd2,
    RD_J = 3'd3,
    WR_I = 3'd4,
    WR_J = 3'd5,
    DONE = 3'd6
  } shuffle_state_t;

  // One LFSR step: shift left, new LSB is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/deck_shuffler_if.sv
// deck_shuffler_if
// Single-port deck memory bus.
//   mem_addr  : word address
//   mem_wen   : write enable
//   mem_wdata : write data
//   mem_rdata : read data, valid one cycle after the address
// master = the block driving the memory, slave = the memory.
interface deck_shuffler_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 7
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wen, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_wen, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/deck_shuffler_lfsr16.sv
// lfsr16
// Free-running 16-bit Fibonacci LFSR.
//   clk : clock
//   rst : synchronous active-high reset, loads SEED
//   q   : current LFSR state
module lfsr16
  import deck_shuffler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Next state is always one step ahead; the register only chooses reset.
  always_comb begin
    q_d = lfsr_step(q_q);
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/deck_shuffler.sv
// deck_shuffler
// In-place Fisher-Yates shuffle of the deck memory, one read-read-write-write
// swap per position, with random indices drawn from a free-running LFSR.
//   clk           : clock
//   rst           : synchronous active-high reset
//   start_shuffle : single-cycle request, ignored while busy
//   mem           : deck memory bus (master side)
//   busy          : shuffle in progress (owns the memory port)
//   shuffle_done  : high from completion until the next accepted start
module deck_shuffler
  import deck_shuffler_pkg::*;
#(
  parameter int          DECK_SIZE = deck_shuffler_pkg::DECK_SIZE,
  parameter int          ADDR_W    = DECK_ADDR_W,
  parameter int          DATA_W    = CARD_W,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_shuffle,
  deck_shuffler_if.master       mem,
  output logic                  busy,
  output logic                  shuffle_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  shuffle_state_t    state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;

  logic [15:0]       lfsr_s;
  logic [ADDR_W-1:0] cand_s;
  logic              unused_lfsr_bits_s;

  logic [ADDR_W-1:0] addr_s;
  logic              wen_s;
  logic [DATA_W-1:0] wdata_s;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_s)
  );

  // Candidate index: low bits of the LFSR, accepted only when <= i.
  assign cand_s             = lfsr_s[ADDR_W-1:0];
  assign unused_lfsr_bits_s = ^lfsr_s[15:ADDR_W];

  // State, index and temporary word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      tmp_q   <= tmp_d;
    end
  end

  // Next-state logic for the shuffle sequence.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    tmp_d   = tmp_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_shuffle) begin
          i_d     = LAST_IDX;
          state_d = PICK;
        end else begin
          state_d = state_q;
        end
      end
      PICK: begin
        // Rejection sampling keeps j uniform without a modulo.
        if (cand_s <= i_q) begin
          j_d     = cand_s;
          state_d = RD_I;
        end else begin
          state_d = PICK;
        end
      end
      RD_I: state_d = RD_J;
      RD_J: begin
        // Read data now carries deck[i] from the RD_I address.
        tmp_d   = mem.mem_rdata;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: begin
        if (i_q == ONE_IDX) begin
          state_d = DONE;
        end else begin
          i_d     = i_q - ONE_IDX;
          state_d = PICK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port decode; everything is zero outside the four memory states.
  always_comb begin
    addr_s  = '0;
    wen_s   = 1'b0;
    wdata_s = '0;
    case (state_q)
      RD_I: addr_s = i_q;
      RD_J: addr_s = j_q;
      WR_I: begin
        // Read data now carries deck[j] from the RD_J address.
        addr_s  = i_q;
        wen_s   = 1'b1;
        wdata_s = mem.mem_rdata;
      end
      WR_J: begin
        addr_s  = j_q;
        wen_s   = 1'b1;
        wdata_s = tmp_q;
      end
      default: begin
        addr_s  = '0;
        wen_s   = 1'b0;
        wdata_s = '0;
      end
    endcase
  end

  assign mem.mem_addr  = addr_s;
  assign mem.mem_wen   = wen_s;
  assign mem.mem_wdata = wdata_s;

  assign busy         = (state_q == PICK) || (state_q == RD_I) || (state_q == RD_J) ||
                        (state_q == WR_I) || (state_q == WR_J);
  assign shuffle_done = (state_q == DONE);

endmodule

// File: tb/tb_deck_shuffler.sv
module tb_deck_shuffler;
  import deck_shuffler_pkg::*;

  localparam int DS = 52;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_shuffle = 1'b0;
  logic busy, shuffle_done;
  logic load_req = 1'b0;

  logic [6:0]  deck [DS];
  logic [15:0] m_lfsr;
  int exp_q[$];
  int n_total = 0;
  int n_bad = 0;

  deck_shuffler_if #(.ADDR_W(6), .DATA_W(7)) mif ();

  deck_shuffler #(.DECK_SIZE(DS), .ADDR_W(6), .DATA_W(7), .SEED(SEED_V)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start_shuffle (start_shuffle),
    .mem           (mif),
    .busy          (busy),
    .shuffle_done  (shuffle_done)
  );

  always #5 clk = ~clk;

  // Deck memory model: 1-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (load_req) begin
      for (int a = 0; a < DS; a++) deck[a] <= 7'(a);
    end else begin
      if (mif.mem_wen && (int'(mif.mem_addr) < DS)) deck[mif.mem_addr] <= mif.mem_wdata;
      if (int'(mif.mem_addr) < DS) mif.mem_rdata <= deck[mif.mem_addr];
      else mif.mem_rdata <= 7'd0;
    end
  end

  // Reference LFSR following the same reset.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED_V;
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Build expected result (cycles then 52 words), drive start, then compare.
  task automatic run_shuffle(input bit poke);
    int md[DS];
    logic [15:0] cur;
    int total, cnt, writes, maxa, gaps, tv, c, seen;
    for (int a = 0; a < DS; a++) md[a] = int'(deck[a]);
    cur = lfsr_step(m_lfsr);
    total = 0;
    for (int i = DS - 1; i >= 1; i--) begin
      do begin
        c = int'(cur[5:0]);
        cur = lfsr_step(cur);
        total++;
      end while (c > i);
      for (int k = 0; k < 4; k++) cur = lfsr_step(cur);
      total += 4;
      tv = md[i]; md[i] = md[c]; md[c] = tv;
    end
    exp_q.push_back(total + 1);
    for (int a = 0; a < DS; a++) exp_q.push_back(md[a]);

    start_shuffle = 1'b1;
    @(negedge clk);
    start_shuffle = 1'b0;
    cnt = 1; writes = 0; maxa = 0; gaps = 0;
    check_eq("accept_busy", int'(busy), 1);
    check_eq("accept_done_low", int'(shuffle_done), 0);
    while (!shuffle_done && cnt < 20000) begin
      if (mif.mem_wen) writes++;
      if (int'(mif.mem_addr) > maxa) maxa = int'(mif.mem_addr);
      if (!busy) gaps++;
      @(negedge clk);
      cnt++;
      start_shuffle = poke && (cnt == 10 || cnt == 100);
    end
    start_shuffle = 1'b0;
    check_eq("done_seen", int'(shuffle_done), 1);
    check_eq("busy_at_done", int'(busy), 0);
    check_eq("busy_gaps", gaps, 0);
    check_eq("cycles", cnt, exp_q.pop_front());
    check_eq("write_cycles", writes, 102);
    check_eq("addr_in_range", int'(maxa <= DS - 1), 1);
    seen = 0;
    for (int a = 0; a < DS; a++) begin
      check_eq($sformatf("deck[%0d]", a), int'(deck[a]), exp_q.pop_front());
    end
    for (int v = 0; v < DS; v++) begin
      for (int a = 0; a < DS; a++) begin
        if (int'(deck[a]) == v) begin
          seen++;
          break;
        end
      end
    end
    check_eq("permutation", seen, DS);
  endtask

  initial begin
    int cnt;
    // Reset with random start activity; loader fills the deck meanwhile.
    rst = 1'b1;
    load_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_shuffle = 1'($urandom);
      @(negedge clk);
    end
    load_req = 1'b0;
    check_eq("rst_addr", int'(mif.mem_addr), 0);
    check_eq("rst_wen", int'(mif.mem_wen), 0);
    check_eq("rst_wdata", int'(mif.mem_wdata), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(shuffle_done), 0);
    check_eq("rst_lfsr", int'(u_dut.lfsr_s), int'(SEED_V));
    rst = 1'b0;
    start_shuffle = 1'b0;
    @(negedge clk);
    check_eq("lfsr_first_step", int'(u_dut.lfsr_s), int'(lfsr_step(SEED_V)));
    check_eq("idle_busy", int'(busy), 0);

    // Full shuffle of the identity deck.
    run_shuffle(1'b0);

    // Fresh deck, starts pulsed while busy must be ignored.
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    run_shuffle(1'b1);

    // Reshuffle current contents straight from DONE.
    run_shuffle(1'b0);

    // Reset during WR_I at i = 30.
    start_shuffle = 1'b1;
    @(negedge clk);
    start_shuffle = 1'b0;
    cnt = 0;
    while (!(u_dut.state_q == WR_I && u_dut.i_q == 6'd30) && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("reached_wr_i_30", int'(u_dut.state_q == WR_I && u_dut.i_q == 6'd30), 1);
    check_eq("wr_i_wen", int'(mif.mem_wen), 1);
    rst = 1'b1;
    start_shuffle = 1'b1;
    @(negedge clk);
    check_eq("midrst_wen", int'(mif.mem_wen), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_done", int'(shuffle_done), 0);
    check_eq("midrst_state", int'(u_dut.state_q), int'(IDLE));
    rst = 1'b0;
    start_shuffle = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check_eq("post_rst_idle", int'(busy), 0);
    run_shuffle(1'b0);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
